// File: rtl/fc_func.sv
// fc_func: function unit of the fully connected layer.
// Accumulates bit-serial CIM partial sums (summed across vertical tiles and
// weighted by bit plane) into per-neuron totals, then on func-start applies
// arithmetic right shift, ReLU and saturation and presents the activations
// to the next layer through a start/ready handshake.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   i_cim_ready        CIM ready; its rising edge marks a finished pass
//   i_count            bit-plane index of the finished pass (0 = LSB)
//   i_psum             tile t / channel c partial sum, signed PSUM_WIDTH
//   i_func_start       request to finalize the current image
//   o_func_ready       high while a func-start can be accepted
//   o_next_start       activation vector valid to the next layer
//   i_next_ready       next layer accepts the activation vector
//   o_data             channel c activation at [c*DATA_SIZE +: DATA_SIZE]
module fc_func #(
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned OUT_CHANNELS = 16,
    parameter int unsigned V_CIM_TILES  = 4,
    parameter int unsigned PSUM_WIDTH   = 8,
    parameter int unsigned SHIFT        = 4,
    parameter int unsigned COUNT_WIDTH  = (DATA_SIZE == 1) ? 1 : $clog2(DATA_SIZE),
    parameter int unsigned ACC_WIDTH    = PSUM_WIDTH + $clog2(V_CIM_TILES) + DATA_SIZE + 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        i_cim_ready,
    input  logic [COUNT_WIDTH-1:0]                      i_count,
    input  logic [V_CIM_TILES*OUT_CHANNELS*PSUM_WIDTH-1:0] i_psum,
    input  logic                                        i_func_start,
    output logic                                        o_func_ready,
    output logic                                        o_next_start,
    input  logic                                        i_next_ready,
    output logic [OUT_CHANNELS*DATA_SIZE-1:0]           o_data
);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        $signed(ACC_WIDTH'((64'd1 << DATA_SIZE) - 64'd1));

    typedef enum logic [1:0] {
        S_ACCUM,
        S_REQUANT,
        S_OUTPUT
    } state_t;

    state_t state;
    state_t state_next;

    logic                               cim_ready_q;
    logic                               pass_c;
    logic                               accept_c;
    logic signed [ACC_WIDTH-1:0]        tile_sum [OUT_CHANNELS];
    logic signed [ACC_WIDTH-1:0]        acc      [OUT_CHANNELS];
    logic signed [ACC_WIDTH-1:0]        acc_next [OUT_CHANNELS];
    logic signed [ACC_WIDTH-1:0]        res      [OUT_CHANNELS];
    logic [OUT_CHANNELS*DATA_SIZE-1:0]  quant_c;

    // Shift, ReLU, then clamp to the unsigned activation range.
    function automatic logic [DATA_SIZE-1:0] requant(input logic signed [ACC_WIDTH-1:0] v);
        logic signed [ACC_WIDTH-1:0] y;
        y = v >>> SHIFT;
        if (y[ACC_WIDTH-1]) begin
            return '0;
        end else if (y > SAT_MAX) begin
            return '1;
        end else begin
            return y[DATA_SIZE-1:0];
        end
    endfunction

    // Pass detection; out-of-range bit planes are dropped.
    assign pass_c   = i_cim_ready && !cim_ready_q && (32'(i_count) < DATA_SIZE);
    assign accept_c = (state == S_ACCUM) && i_func_start;

    // Sign-extended sum of all vertical tiles per channel.
    always_comb begin
        for (int c = 0; c < OUT_CHANNELS; c++) begin
            tile_sum[c] = '0;
            for (int t = 0; t < V_CIM_TILES; t++) begin
                tile_sum[c] = tile_sum[c] + ACC_WIDTH'($signed(
                    i_psum[(t*OUT_CHANNELS+c)*PSUM_WIDTH +: PSUM_WIDTH]));
            end
        end
    end

    // Bit-plane weighted accumulation.
    always_comb begin
        for (int c = 0; c < OUT_CHANNELS; c++) begin
            acc_next[c] = acc[c];
            if (pass_c) begin
                acc_next[c] = acc[c] + (tile_sum[c] <<< i_count);
            end
        end
    end

    // Requantized image result.
    always_comb begin
        quant_c = '0;
        for (int c = 0; c < OUT_CHANNELS; c++) begin
            quant_c[c*DATA_SIZE +: DATA_SIZE] = requant(res[c]);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_ACCUM:   if (i_func_start) state_next = S_REQUANT;
            S_REQUANT: state_next = S_OUTPUT;
            S_OUTPUT:  if (i_next_ready) state_next = S_ACCUM;
            default:   state_next = S_ACCUM;
        endcase
    end

    // Handshake outputs registered from the next state so they track the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_func_ready <= 1'b1;
            o_next_start <= 1'b0;
        end else begin
            o_func_ready <= (state_next == S_ACCUM);
            o_next_start <= (state_next == S_OUTPUT);
        end
    end

    // Accumulators, finalized snapshot and output data.
    // cim_ready_q resets high so a CIM ready held through reset is not a pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cim_ready_q <= 1'b1;
            o_data      <= '0;
            for (int c = 0; c < OUT_CHANNELS; c++) begin
                acc[c] <= '0;
                res[c] <= '0;
            end
        end else begin
            cim_ready_q <= i_cim_ready;
            for (int c = 0; c < OUT_CHANNELS; c++) begin
                if (accept_c) begin
                    res[c] <= acc_next[c];
                    acc[c] <= '0;
                end else begin
                    acc[c] <= acc_next[c];
                end
            end
            if (state == S_REQUANT) begin
                o_data <= quant_c;
            end
        end
    end

endmodule

// File: tb/tb_fc_func.sv
// Testbench for fc_func: directed cases plus randomized images, checked
// against a per-image arithmetic model of accumulation and requantization.
module tb_fc_func;

    localparam int DS = 8;
    localparam int OC = 16;
    localparam int VT = 4;
    localparam int PW = 8;
    localparam int SH = 4;
    localparam int CW = 3;

    logic                  clk;
    logic                  rst;
    logic                  i_cim_ready;
    logic [CW-1:0]         i_count;
    logic [VT*OC*PW-1:0]   i_psum;
    logic                  i_func_start;
    logic                  o_func_ready;
    logic                  o_next_start;
    logic                  i_next_ready;
    logic [OC*DS-1:0]      o_data;

    fc_func dut (
        .clk          (clk),
        .rst          (rst),
        .i_cim_ready  (i_cim_ready),
        .i_count      (i_count),
        .i_psum       (i_psum),
        .i_func_start (i_func_start),
        .o_func_ready (o_func_ready),
        .o_next_start (o_next_start),
        .i_next_ready (i_next_ready),
        .o_data       (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model state
    int          ps [VT][OC];
    longint      m_acc [OC];
    longint      m_res [OC];
    int          phase;          // 0 accumulate, 1 requantize, 2 output
    logic        prev_rdy;
    logic [OC*DS-1:0] exp_data;

    task automatic chk(input string tag, input logic [OC*DS-1:0] got, input logic [OC*DS-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [OC*DS-1:0] model_quant();
        logic [OC*DS-1:0] r;
        longint y;
        r = '0;
        for (int c = 0; c < OC; c++) begin
            if (m_res[c] < 0) y = 0;
            else y = m_res[c] / (longint'(1) << SH);
            if (y > (longint'(1) << DS) - 1) y = (longint'(1) << DS) - 1;
            r[c*DS +: DS] = DS'(y);
        end
        return r;
    endfunction

    task automatic set_psum();
        for (int t = 0; t < VT; t++)
            for (int c = 0; c < OC; c++)
                i_psum[(t*OC+c)*PW +: PW] = PW'(ps[t][c]);
    endtask

    task automatic clear_ps();
        for (int t = 0; t < VT; t++)
            for (int c = 0; c < OC; c++)
                ps[t][c] = 0;
    endtask

    // One clock cycle of stimulus, model update and output checks.
    task automatic drive(input logic rdy, input int cnt, input logic fs, input logic nr);
        longint s;
        i_cim_ready  = rdy;
        i_count      = CW'(cnt);
        i_func_start = fs;
        i_next_ready = nr;
        set_psum();
        if (rdy && !prev_rdy && cnt < DS) begin
            for (int c = 0; c < OC; c++) begin
                s = 0;
                for (int t = 0; t < VT; t++) s += ps[t][c];
                m_acc[c] += s * (longint'(1) << cnt);
            end
        end
        prev_rdy = rdy;
        case (phase)
            0: if (fs) begin
                for (int c = 0; c < OC; c++) begin
                    m_res[c] = m_acc[c];
                    m_acc[c] = 0;
                end
                phase = 1;
            end
            1: begin
                exp_data = model_quant();
                phase = 2;
            end
            default: if (nr) phase = 0;
        endcase
        @(posedge clk);
        #1;
        chk("func_ready", o_func_ready, phase == 0);
        chk("next_start", o_next_start, phase == 2);
        if (phase == 2) chk("data", o_data, exp_data);
    endtask

    task automatic pass(input int k, input logic fs);
        drive(1'b0, k, 1'b0, 1'b0);
        drive(1'b1, k, fs, 1'b0);
    endtask

    // Func-start (optionally coincident with a last pass at plane cnt), then
    // advance to the first output cycle.
    task automatic start_fin(input int cnt);
        if (cnt >= 0) pass(cnt, 1'b1);
        else drive(1'b0, 0, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    // Hold backpressure for bp cycles while feeding npass next-image passes.
    task automatic drain(input int bp, input int npass, input int base, input logic fs_noise);
        int guard;
        int k;
        logic rdy;
        guard = 0;
        k = base;
        while (phase != 0 && guard < 64) begin
            rdy = 1'b0;
            if (npass > 0 && !prev_rdy) begin
                rdy = 1'b1;
                npass--;
            end
            drive(rdy, k % DS, fs_noise && guard == 0, bp == 0);
            if (rdy) k++;
            if (bp > 0) bp--;
            guard++;
        end
        if (phase != 0) chk("drain_timeout", 1'b0, 1'b1);
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic apply_reset();
        i_func_start = 1'b0;
        i_next_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_func_ready", o_func_ready, 1'b1);
        chk("rst_next_start", o_next_start, 1'b0);
        chk("rst_data", o_data, '0);
        for (int c = 0; c < OC; c++) begin
            m_acc[c] = 0;
            m_res[c] = 0;
        end
        phase    = 0;
        exp_data = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        prev_rdy = i_cim_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_image();
        int amp;
        logic coinc;
        amp   = int'($urandom_range(1, 127));
        coinc = 1'($urandom_range(0, 1));
        for (int k = 0; k < DS; k++) begin
            for (int t = 0; t < VT; t++)
                for (int c = 0; c < OC; c++)
                    ps[t][c] = int'($urandom_range(0, 2*amp)) - amp;
            repeat ($urandom_range(0, 2)) drive(1'b0, 0, 1'b0, 1'b0);
            if (k == DS-1 && coinc) begin
                drive(1'b0, k, 1'b0, 1'b0);
                drive(1'b1, k, 1'b1, 1'b0);
                drive(1'b0, 0, 1'b0, 1'b0);
            end else begin
                pass(k, 1'b0);
            end
        end
        if (!coinc) start_fin(-1);
        drain(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, DS-1)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_ps();
        ps[0][0]     = 100;
        rst          = 1'b1;
        i_cim_ready  = 1'b1;
        i_count      = '0;
        i_func_start = 1'b0;
        i_next_ready = 1'b0;
        set_psum();
        prev_rdy     = 1'b1;
        phase        = 0;
        exp_data     = '0;
        for (int c = 0; c < OC; c++) begin
            m_acc[c] = 0;
            m_res[c] = 0;
        end
        @(posedge clk);
        #1;
        apply_reset();

        // CIM ready held high across reset release is not a pass
        repeat (3) drive(1'b1, 0, 1'b0, 1'b0);
        start_fin(-1);
        chk("no_acc_after_reset", o_data, '0);
        drain(0, 0, 0, 1'b0);

        // Accumulation over all planes: 3*255 = 765, >>4 = 47
        clear_ps();
        ps[0][0] = 3;
        for (int k = 0; k < DS; k++) pass(k, 1'b0);
        start_fin(-1);
        chk("sat_ch0", o_data[7:0], 8'd47);
        chk("sat_others", o_data[OC*DS-1:8], '0);
        drain(1, 0, 0, 1'b0);

        // ReLU: -2*255 = -510 -> 0
        ps[0][0] = -2;
        for (int k = 0; k < DS; k++) pass(k, 1'b0);
        start_fin(-1);
        chk("relu_ch0", o_data[7:0], 8'd0);
        drain(0, 0, 0, 1'b0);

        // Tile sum: (1+2+3+4)<<7 = 1280, >>4 = 80
        clear_ps();
        ps[0][5] = 1; ps[1][5] = 2; ps[2][5] = 3; ps[3][5] = 4;
        pass(7, 1'b0);
        start_fin(-1);
        chk("tilesum_ch5", o_data[47:40], 8'd80);
        drain(0, 0, 0, 1'b0);

        // Clipping: 127*255>>4 = 2024 -> 255
        clear_ps();
        ps[0][0] = 127;
        for (int k = 0; k < DS; k++) pass(k, 1'b0);
        start_fin(-1);
        chk("clip_ch0", o_data[7:0], 8'd255);
        drain(0, 0, 0, 1'b0);

        // Last pass coincident with func-start, then backpressure with new passes
        clear_ps();
        ps[0][0] = 1;
        start_fin(7);
        chk("coinc_ch0", o_data[7:0], 8'd8);
        drain(5, 2, 4, 1'b1);
        start_fin(-1);
        chk("carry_ch0", o_data[7:0], 8'd3);
        drain(0, 0, 0, 1'b0);

        // Abort in output phase, then an image computed from zero
        clear_ps();
        ps[1][2] = 50;
        pass(0, 1'b0);
        start_fin(-1);
        chk("pre_abort_ch2", o_data[23:16], 8'd3);
        apply_reset();
        clear_ps();
        ps[2][3] = 5;
        pass(2, 1'b0);
        start_fin(-1);
        chk("after_abort_ch3", o_data[31:24], 8'd1);
        chk("after_abort_ch2", o_data[23:16], 8'd0);
        drain(0, 0, 0, 1'b0);

        // Randomized images
        for (int n = 0; n < 25; n++) rand_image();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fc_func.md
# fc_func

Function unit of the fully connected layer, directly downstream of the flatten/FC controller and the CIM tiles.
- Accumulates the bit-serial CIM partial sums, one per input bit plane, into per-neuron totals with shift-add across vertical tiles.
- On the controller's func-start it applies arithmetic right shift, ReLU and saturation.
- It then presents one DATA_SIZE-bit activation per neuron to the next layer through a start/ready handshake.

## Interface
Parameters:
- DATA_SIZE, 8: activation bit width; number of bit-serial CIM passes per image.
- OUT_CHANNELS, 16: neurons (crossbar columns) handled.
- V_CIM_TILES, 4: vertical CIM tiles whose partial sums are added.
- PSUM_WIDTH, 8: signed two's-complement width of one tile/column partial sum.
- SHIFT, 4: requantization right-shift amount.
- COUNT_WIDTH, (DATA_SIZE==1) ? 1 : $clog2(DATA_SIZE): bit-plane index width.
- ACC_WIDTH, PSUM_WIDTH + $clog2(V_CIM_TILES) + DATA_SIZE + 1: signed accumulator width.

Ports:
- clk, in, 1: clock; all state on rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- i_cim_ready, in, 1: CIM ready, shared with the controller. Its rising edge marks a finished pass.
- i_count, in, COUNT_WIDTH: bit-plane index of the pass just finished; 0 = LSB.
- i_psum, in, V_CIM_TILES*OUT_CHANNELS*PSUM_WIDTH: tile t, channel c at [(t*OUT_CHANNELS+c)*PSUM_WIDTH +: PSUM_WIDTH].
- i_func_start, in, 1: controller request to finalize the image.
- o_func_ready, out, 1: high when a func-start is accepted.
- o_next_start, out, 1: output valid to the next layer.
- i_next_ready, in, 1: next layer accepts.
- o_data, out, OUT_CHANNELS*DATA_SIZE: channel c at [c*DATA_SIZE +: DATA_SIZE], unsigned.

## Operation
- Edge detect:
  - cim_ready_q registers i_cim_ready; reset value 1.
  - A pass completes when i_cim_ready && !cim_ready_q.
- Accumulate on a pass, in any state, for every c: acc[c] += sign_ext(sum over t of psum[t][c]) <<< i_count.
  - A pass with i_count >= DATA_SIZE is ignored.
- States:
  - S_ACCUM: o_func_ready=1, o_next_start=0. On i_func_start:
    - res[c] <= acc_next[c], which includes any pass edge in the same cycle.
    - acc[c] <= 0.
    - Go to S_REQUANT.
  - S_REQUANT: o_func_ready=0. Compute y = res[c] >>> SHIFT, then:
    - y<0 gives 0.
    - y>2^DATA_SIZE-1 gives 2^DATA_SIZE-1.
    - Otherwise y[DATA_SIZE-1:0].
    - Register into o_data, then go to S_OUTPUT.
  - S_OUTPUT: o_next_start=1 and o_data held stable. When i_next_ready=1, transfer completes and the block returns to S_ACCUM.
- Passes for the next image may arrive in S_REQUANT or S_OUTPUT. They accumulate into the cleared acc and must not disturb res or o_data.
- i_func_start while o_func_ready=0 is ignored.
- Reset values:
  - State S_ACCUM, so o_func_ready=1.
  - o_next_start=0, o_data=0, acc=0, res=0, cim_ready_q=1.
- Reset mid-operation aborts everything; no output is produced for the aborted image.

## Timing
- Cycle 0: i_func_start && o_func_ready.
- Cycle 1: S_REQUANT.
- Cycle 2: o_next_start=1 with valid o_data; latency is 2 cycles.
- If i_next_ready=1 in cycle 2, cycle 3 has o_func_ready=1. Minimum 3 cycles per image in the finalize path.
- A pass edge and i_func_start in the same cycle, which is the controller's normal last pass: that partial sum is included in the result.
- o_next_start stays high until the handshake cycle and drops the cycle after.
- Accumulation takes effect at the edge ending the detection cycle. Throughput is one pass per 2 cycles minimum, since a rising edge needs a preceding low cycle.
- No wrap-around with default widths. Non-default ACC_WIDTH too small truncates silently; that is not allowed by rule.

## Test plan
- Reset:
  - Stimulus: assert rst asynchronously mid-cycle.
  - Required: o_func_ready=1, o_next_start=0, o_data=0 immediately. No accumulation on the first i_cim_ready high after release.
- Saturation:
  - Stimulus: 1 channel active, all tiles psum tile0=3, others 0, passes count 0..7, then func_start.
  - Required: acc=765, >>4=47. o_data ch0=47 at cycle+2; others 0.
- ReLU:
  - Stimulus: tile0 psum=-2 on all 8 passes, func_start.
  - Required: acc=-510, output 0.
- Tile sum with clipping:
  - Stimulus: tiles 1,2,3,4 on ch5 at count=7 only.
  - Required: 10<<7=1280, >>4=80.
  - Also: tile0=127 on all passes gives 127*255>>4=2024, saturating to o_data=255.
- Last pass coincident with func_start, plus backpressure:
  - Stimulus: last pass coincident with func_start, psum=1 at count 7; then i_next_ready low 5 cycles; meanwhile two new passes arrive.
  - Required: o_next_start held 5+ cycles, o_data constant and including the 128 contribution. New passes land in the next image's result.
- Abort:
  - Stimulus: rst in S_OUTPUT.
  - Required: o_next_start drops at once; a following image computes from zero.
